// File: rtl/alarm_countdown.sv
// rtl/alarm_countdown.sv - mm:ss BCD countdown with ring, acknowledge, timeout and optional snooze (SNOOZE_EN)
module alarm_countdown #(
    parameter int TICKS_PER_SEC    = 100_000_000,
    parameter int RING_TIMEOUT_SEC = 30,
    parameter int SNOOZE_SEC       = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [15:0] alarm_in,
    input  logic        push_c,
    input  logic        push_u,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        ringing,
    output logic        ring_led,
    output logic        done,
    output logic        missed
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RING = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int             PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [7:0]     RING_LAST  = 8'(RING_TIMEOUT_SEC);

`ifdef SNOOZE_EN
    localparam logic [15:0] SNOOZE_BCD = {8'h00, 4'(SNOOZE_SEC / 10), 4'(SNOOZE_SEC % 10)};
`else
    logic unused_snooze;
    assign unused_snooze = push_u ^ (SNOOZE_SEC == 0);
`endif

    state_t        state_q, state_d;
    logic          start_q;
    logic [15:0]   time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          paused_q, paused_d;
    logic [7:0]    ring_cnt_q, ring_cnt_d;
    logic          ring_led_q, ring_led_d;
    logic          missed_q, missed_d;
    logic          running_q, ringing_q, done_q;

    logic          start_edge;
    logic          presc_tc;
    logic [15:0]   time_dec;

    // Subtract one second from an mm:ss BCD value; minutes borrow 0->9, seconds tens borrow 0->5.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = t;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign start_edge = start & ~start_q;
    assign presc_tc   = (presc_q == PRESC_LAST);
    assign time_dec   = bcd_dec(time_q);

    // State and datapath registers; outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            time_q     <= 16'h0000;
            presc_q    <= '0;
            paused_q   <= 1'b0;
            ring_cnt_q <= 8'd0;
            ring_led_q <= 1'b0;
            missed_q   <= 1'b0;
            running_q  <= 1'b0;
            ringing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            time_q     <= time_d;
            presc_q    <= presc_d;
            paused_q   <= paused_d;
            ring_cnt_q <= ring_cnt_d;
            ring_led_q <= ring_led_d;
            missed_q   <= missed_d;
            running_q  <= (state_d == S_RUN) && !paused_d;
            ringing_q  <= (state_d == S_RING);
            done_q     <= (state_d == S_DONE);
        end
    end

    // Next-state logic: load on start edge, count down in RUN, ring until acknowledge or timeout.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        paused_d   = paused_q;
        ring_cnt_d = ring_cnt_q;
        ring_led_d = ring_led_q;
        missed_d   = missed_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                ring_led_d = 1'b0;
                if (start_edge) begin
                    time_d     = alarm_in;
                    presc_d    = '0;
                    paused_d   = 1'b0;
                    missed_d   = 1'b0;
                    ring_cnt_d = 8'd0;
                    ring_led_d = 1'b0;
                    state_d    = (alarm_in == 16'h0000) ? S_RING : S_RUN;
                end
            end

            S_RUN: begin
                if (push_c) begin
                    paused_d = ~paused_q;
                end
                if (!paused_q) begin
                    if (presc_tc) begin
                        presc_d = '0;
                        time_d  = time_dec;
                        if (time_dec == 16'h0000) begin
                            state_d    = S_RING;
                            ring_cnt_d = 8'd0;
                            ring_led_d = 1'b0;
                            paused_d   = 1'b0;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end
            end

            S_RING: begin
                if (presc_tc) begin
                    presc_d    = '0;
                    ring_led_d = ~ring_led_q;
                    ring_cnt_d = ring_cnt_q + 8'd1;
                    if ((ring_cnt_q + 8'd1) == RING_LAST) begin
                        state_d    = S_DONE;
                        missed_d   = 1'b1;
                        ring_led_d = 1'b0;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
`ifdef SNOOZE_EN
                if (push_u) begin
                    state_d    = S_RUN;
                    time_d     = SNOOZE_BCD;
                    presc_d    = '0;
                    ring_cnt_d = 8'd0;
                    ring_led_d = 1'b0;
                    paused_d   = 1'b0;
                    missed_d   = 1'b0;
                end
`endif
                // Acknowledge has priority over both timeout and snooze.
                if (push_c) begin
                    state_d    = S_DONE;
                    missed_d   = 1'b0;
                    ring_led_d = 1'b0;
                    time_d     = time_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign time_bcd = time_q;
    assign running  = running_q;
    assign ringing  = ringing_q;
    assign ring_led = ring_led_q;
    assign done     = done_q;
    assign missed   = missed_q;

endmodule

// File: doc/alarm_countdown.md
# alarm_countdown

Countdown-and-ring stage fed by the alarm-set stage. When the setter raises its finish flag, this block latches the 16-bit BCD mm:ss value and counts it down once per second. It drives the running value to the 7-segment display mux and raises a ring indication at 00:00. The ring ends on user acknowledge or on timeout.

## Interface
- TICKS_PER_SEC, 100_000_000: clk cycles per countdown second (≥2).
- RING_TIMEOUT_SEC, 30: seconds of unacknowledged ringing before forced stop (1..255).
- SNOOZE_SEC, 10: snooze reload value in seconds (1..59). Used only with SNOOZE_EN.
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  level from setter finish flag; its rising edge starts a run.
- alarm_in  in  16  BCD [15:12]=min tens, [11:8]=min ones, [7:4]=sec tens, [3:0]=sec ones; each digit 0-9.
- push_c  in  1  single-cycle debounced pulse: pause/resume in RUN, acknowledge in RING.
- push_u  in  1  single-cycle debounced pulse: snooze in RING (SNOOZE_EN only).
- time_bcd  out  16  current remaining time, same digit layout as alarm_in.
- running  out  1  high in RUN while not paused.
- ringing  out  1  high in RING.
- ring_led  out  1  toggles once per second while ringing; 0 otherwise.
- done  out  1  high in DONE.
- missed  out  1  high in DONE when the ring timed out without acknowledge.

## Operation
- States: IDLE, RUN, RING, DONE. Reset: IDLE; all outputs 0; time_bcd=0000; prescaler, paused flag and ring-second counter cleared.
- start edge detect: one register holds previous start; edge = start & ~start_q. start_q resets to 0.
- IDLE/DONE + edge: time_bcd←alarm_in, prescaler←0, paused←0, done/missed←0.
  - Goes to RING if alarm_in==0000, else to RUN.
  - An edge in RUN or RING is ignored.
- RUN: prescaler counts 0..TICKS_PER_SEC-1 while not paused. At terminal count, time_bcd decrements by one second:
  - sec ones 0→9 with borrow into sec tens;
  - sec tens 0→5 with borrow into min ones;
  - min ones 0→9 with borrow into min tens.
  - Loaded sec tens >5 counts down normally (e.g. 00:75→00:74).
- A decrement that produces 0000 moves the block to RING on the same edge, with prescaler←0 and ring counter←0.
- push_c in RUN toggles paused. A paused block holds the prescaler value.
- push_c on the same cycle as the terminal count: the decrement happens and paused toggles.
- RING: ringing=1. The prescaler keeps running. Each terminal count toggles ring_led and increments the ring counter.
  - push_c → DONE, missed=0.
  - Ring counter reaching RING_TIMEOUT_SEC → DONE, missed=1.
  - push_c on the timeout cycle: push_c wins, missed=0.
- DONE: done=1, time_bcd holds 0000, ring_led=0. Stays in DONE until a start edge or reset.
- resetn low in any state returns to IDLE on the next edge. Any in-flight count is discarded.

## Timing
- All outputs are registered.
- Start edge at cycle N: start_q updates at N. State and time_bcd update at N+1.
- First decrement happens exactly TICKS_PER_SEC cycles after RUN entry. Later decrements follow every TICKS_PER_SEC cycles of unpaused time.
- push_c/push_u take effect on the edge that samples them. Pulses longer than one cycle are not supported.
- RING→DONE via timeout occurs RING_TIMEOUT_SEC×TICKS_PER_SEC cycles after RING entry.

## Configuration
- SNOOZE_EN defined:
  - push_u in RING sets time_bcd to 00:SNOOZE_SEC in BCD and clears the prescaler, ring counter and ring_led.
  - The state returns to RUN.
  - push_c on the same cycle wins (acknowledge).
- SNOOZE_EN undefined: push_u is ignored everywhere. No snooze logic is synthesized.

## Test plan
- TICKS_PER_SEC=4, alarm_in=0x0012, start rises:
  - time_bcd reads 0011 after 4 cycles and 0000 after 48 cycles;
  - ringing=1 on that same edge.
- alarm_in=0x0100: after one tick time_bcd=0x0059. alarm_in=0x1000: after one tick time_bcd=0x0959.
- alarm_in=0x0000, start rises → RING one cycle later. With no push_c and RING_TIMEOUT_SEC=3 → DONE with missed=1 after 12 cycles.
- In RUN, push_c at cycle 2 → time_bcd frozen for 20 cycles. push_c again → decrement 2 cycles later. Start edge mid-RUN is ignored.
- In RING, push_c → done=1, missed=0. Start falls then rises with 0x0005 → reload and RUN.
- SNOOZE_EN, SNOOZE_SEC=10: push_u in RING → time_bcd=0x0010, RUN. Without the macro, the same pulse leaves ringing=1.
